// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scans four active-low 7-seg digits over one seg bus.
// `define SCAN_BLINK_EN blinks the digit pair being adjusted.
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int GUARD_CYCLES = 4,
  parameter int BLINK_DIV    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       adj,
  input  logic       sel,
  input  logic [7:0] digit0,
  input  logic [7:0] digit1,
  input  logic [7:0] digit2,
  input  logic [7:0] digit3,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] scan_idx
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GEND = CW'(GUARD_CYCLES);

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } state_t;

  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    idx_nxt;
  state_t        state;
  logic [7:0]    pat;
  logic [7:0]    seg_d;
  logic [3:0]    an_d;
  logic          dark;

`ifdef SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // Free-running blink phase, independent of enable
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Blank the selected pair during the off phase
  always_comb dark = adj && blink_ph && (scan_idx[1] == sel);
`else
  logic unused_blink;
  assign unused_blink = ^{adj, sel, BLINK_DIV};

  // No blinking: slots only follow guard/drive
  always_comb dark = 1'b0;
`endif

  // State register: slot position and digit index, plus registered pins
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      scan_idx <= 2'd0;
      seg      <= 8'hFF;
      an       <= 4'hF;
    end else begin
      slot_cnt <= cnt_nxt;
      scan_idx <= idx_nxt;
      seg      <= seg_d;
      an       <= an_d;
    end
  end

  // Slot phase is a pure function of the slot counter
  always_comb state = (slot_cnt < GEND) ? GUARD : DRIVE;

  // Next counters; disable parks the slot at 0 so re-enable starts in guard
  always_comb begin
    cnt_nxt = slot_cnt;
    idx_nxt = scan_idx;
    if (!enable) begin
      cnt_nxt = '0;
    end else if (slot_cnt == LAST) begin
      cnt_nxt = '0;
      idx_nxt = scan_idx + 2'd1;
    end else begin
      cnt_nxt = slot_cnt + 1'b1;
    end
  end

  // Pattern of the digit owning the current slot
  always_comb begin
    pat = 8'hFF;
    unique case (scan_idx)
      2'd0: pat = digit0;
      2'd1: pat = digit1;
      2'd2: pat = digit2;
      2'd3: pat = digit3;
    endcase
  end

  // Pin drive: at most one anode low, everything off otherwise
  always_comb begin
    seg_d = 8'hFF;
    an_d  = 4'hF;
    if (enable && state == DRIVE && !dark) begin
      an_d  = ~(4'b0001 << scan_idx);
      seg_d = pat;
    end
  end

endmodule
